// File: rtl/spi_pkg.sv
// SPI responder shared types.
// State encoding and default frame width.
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input.
// Resets to a chosen idle level.
module spi_sync #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] r_ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ff <= {DEPTH{RST_VAL}};
    end else begin
      r_ff <= (r_ff << 1) | DEPTH'(d);
    end
  end

  assign q = r_ff[DEPTH-1];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder, oversampled by the system clock.
// Frames of WIDTH bits, MSB first, reply preloaded via tx_load.
module spi_responder
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_pending,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  logic w_sclk;
  logic w_cs;
  logic w_mosi;

  spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk  (clk),
    .reset(reset),
    .d    (sclk),
    .q    (w_sclk)
  );

  spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk  (clk),
    .reset(reset),
    .d    (cs),
    .q    (w_cs)
  );

  spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk  (clk),
    .reset(reset),
    .d    (mosi),
    .q    (w_mosi)
  );

  logic r_sclk_d;
  logic r_cs_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sclk_d <= w_sclk;
      r_cs_d   <= w_cs;
    end
  end

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;

  spi_state_t       r_state;
  spi_state_t       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pend;
  logic             r_pending;
  logic [WIDTH-1:0] r_txsh;
  logic [WIDTH-1:0] r_rxsh;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;

  logic w_cap;
  logic w_rx_shift;
  logic w_tx_shift;
  logic w_done;
  logic w_abort;
  logic w_exit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_rx_shift  = 1'b0;
    w_tx_shift  = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_exit      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_cap       = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Every counter value seen here is below WIDTH
        if (w_cs_rise) begin
          w_abort     = 1'b1;
          w_exit      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_sclk_rise) begin
          w_rx_shift = 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_done      = 1'b1;
            w_state_nxt = DONE;
          end
        end else if (w_sclk_fall) begin
          w_tx_shift = 1'b1;
        end
      end
      DONE: begin
        if (w_cs_rise) begin
          w_exit      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_txsh <= '0;
      r_rxsh <= '0;
      r_cnt  <= '0;
    end else if (w_cap) begin
      r_txsh <= r_pending ? r_pend : '0;
      r_rxsh <= '0;
      r_cnt  <= '0;
    end else if (w_exit) begin
      r_txsh <= '0;
      r_cnt  <= '0;
    end else if (w_tx_shift) begin
      r_txsh <= r_txsh << 1;
    end else if (w_rx_shift) begin
      r_rxsh <= {r_rxsh[WIDTH-2:0], w_mosi};
      if (r_cnt < CW'(WIDTH)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // A load in the capture cycle wins, so it survives for the next frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend    <= '0;
      r_pending <= 1'b0;
    end else if (tx_load) begin
      r_pend    <= tx_data;
      r_pending <= 1'b1;
    end else if (w_cap) begin
      r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= w_done;
      r_frame_err <= w_abort;
      if (w_done) begin
        r_rx_data <= {r_rxsh[WIDTH-2:0], w_mosi};
      end
    end
  end

  assign miso_oe    = ~w_cs;
  assign miso       = r_txsh[WIDTH-1] & ~w_cs;
  assign tx_pending = r_pending;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: table of full frames
// plus abort, capture-cycle load and mid-frame reset sequences.
module tb_spi_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_pending;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int rxv_cnt = 0;
  int ferr_cnt = 0;

  always #10 clk = ~clk;

  spi_responder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_pending(tx_pending),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rxv_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
  end

  typedef struct {
    logic [7:0] ld1;
    bit         use1;
    logic [7:0] ld2;
    bit         use2;
    logic [7:0] mo;
    logic [7:0] exp_mi;
    logic [7:0] exp_rx;
    int         gap;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Master at clk/4; miso is taken just before each falling edge
  task automatic xfer(input logic [7:0] mo, input int nbits,
                      input int ld_at, input logic [7:0] ld_val,
                      input bit end_cs, input int gap,
                      output logic [7:0] mi);
    mi   = '0;
    cs   = 1'b0;
    mosi = mo[7];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == ld_at) begin
        tx_data = ld_val;
        tx_load = 1'b1;
      end else begin
        tx_load = 1'b0;
      end
    end
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      @(negedge clk);
      mi   = {mi[6:0], miso};
      sclk = 1'b0;
      if (i < 7) mosi = mo[6-i];
      repeat (2) @(negedge clk);
    end
    if (end_cs) begin
      cs = 1'b1;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] mo,
                           input int ld_at, input logic [7:0] ld_val,
                           input int gap, input logic [7:0] exp_mi,
                           input logic [7:0] exp_rx,
                           input logic exp_pend);
    logic [7:0] mi;
    int v0;
    int f0;
    v0 = rxv_cnt;
    f0 = ferr_cnt;
    xfer(mo, 8, ld_at, ld_val, 1'b1, gap, mi);
    chk({tag, "_miso"}, mi, exp_mi);
    chk({tag, "_rx"}, rx_data, exp_rx);
    chk({tag, "_rxv"}, rxv_cnt - v0, 1);
    chk({tag, "_ferr"}, ferr_cnt - f0, 0);
    chk({tag, "_pend"}, tx_pending, exp_pend);
    chk({tag, "_oe"}, {miso_oe, miso}, 2'b00);
  endtask

  initial begin
    logic [7:0] mi;
    int v0;
    int f0;

    vecs[0] = '{8'h05, 1'b1, 8'h00, 1'b0, 8'hA3, 8'h05, 8'hA3, 6};
    vecs[1] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h01, 8'h00, 8'h01, 6};
    vecs[2] = '{8'h04, 1'b1, 8'h08, 1'b1, 8'hC6, 8'h08, 8'hC6, 4};
    vecs[3] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h7E, 8'h00, 8'h7E, 4};
    vecs[4] = '{8'hFF, 1'b1, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 6};
    vecs[5] = '{8'h80, 1'b1, 8'h00, 1'b0, 8'hFF, 8'h80, 8'hFF, 6};

    reset   = 1'b0;
    sclk    = 1'b0;
    cs      = 1'b1;
    mosi    = 1'b0;
    tx_load = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_pend", tx_pending, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_ferr", frame_err, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].use1) load(vecs[i].ld1);
      if (vecs[i].use2) load(vecs[i].ld2);
      chk($sformatf("vec%0d_pend0", i), tx_pending,
          vecs[i].use1 | vecs[i].use2);
      run_frame($sformatf("vec%0d", i), vecs[i].mo, -1, 8'h00,
                vecs[i].gap, vecs[i].exp_mi, vecs[i].exp_rx, 1'b0);
    end

    // Abort after 5 bits: reply 0x0B is consumed and lost
    load(8'h0B);
    v0 = rxv_cnt;
    f0 = ferr_cnt;
    xfer(8'h35, 5, -1, 8'h00, 1'b1, 6, mi);
    chk("abort_miso", mi[4:0], 5'b00001);
    chk("abort_ferr", ferr_cnt - f0, 1);
    chk("abort_rxv", rxv_cnt - v0, 0);
    chk("abort_rx", rx_data, 8'hFF);
    chk("abort_pend", tx_pending, 0);
    run_frame("post_abort", 8'h02, -1, 8'h00, 6, 8'h00, 8'h02, 1'b0);

    // Load exactly in the synchronized cs-fall capture cycle
    load(8'h03);
    run_frame("cap_load", 8'h11, 1, 8'h07, 6, 8'h03, 8'h11, 1'b1);
    run_frame("cap_next", 8'h22, -1, 8'h00, 6, 8'h07, 8'h22, 1'b0);

    // Reset in the middle of a frame
    v0 = rxv_cnt;
    f0 = ferr_cnt;
    xfer(8'h5A, 4, 3, 8'h55, 1'b0, 0, mi);
    chk("mid_pend", tx_pending, 1);
    chk("mid_oe", miso_oe, 1);
    reset = 1'b0;
    #1;
    chk("arst_miso", miso, 0);
    chk("arst_oe", miso_oe, 0);
    chk("arst_pend", tx_pending, 0);
    chk("arst_rx", rx_data, 0);
    chk("arst_rxv", rx_valid, 0);
    chk("arst_ferr", frame_err, 0);
    @(negedge clk);
    cs   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_no_rxv", rxv_cnt - v0, 0);
    chk("arst_no_ferr", ferr_cnt - f0, 0);
    run_frame("post_rst", 8'h09, -1, 8'h00, 6, 8'h00, 8'h09, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the frame length in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on sclk/cs/mosi.
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sclk  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
REQ-006 SHALL have port cs  input  1  chip select from master, active-low.
REQ-007 SHALL have port mosi  input  1  serial data from master, MSB first.
REQ-008 SHALL have port miso  output  1  serial data to master, MSB first.
REQ-009 SHALL have port miso_oe  output  1  high while cs is asserted (synchronized); pad driver enable.
REQ-010 SHALL have port tx_data  input  WIDTH  reply word, e.g. zero-extended 4-bit board position.
REQ-011 SHALL have port tx_load  input  1  one-cycle strobe; writes tx_data into the pending reply register.
REQ-012 SHALL have port tx_pending  output  1  high while a loaded reply has not yet been sent.
REQ-013 SHALL have port rx_data  output  WIDTH  last complete word received from the master.
REQ-014 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-015 SHALL have port frame_err  output  1  one-cycle pulse when cs deasserts mid-frame.

Function
REQ-016 SHALL sample sclk, cs and mosi through SYNC_STAGES flip-flops; edges SHALL be detected on the synchronized signals; the supported sclk rate SHALL be at most clk/4 (12.5 MHz).
REQ-017 SHALL implement the states IDLE, SHIFT and DONE.
REQ-018 In IDLE, on a cs falling edge, SHALL copy the pending reply into the shift-out register (0x00 if none is pending), clear tx_pending, reset the bit counter to 0, drive miso with the MSB, and enter SHIFT.
REQ-019 In SHIFT, on each sclk rising edge, SHALL shift mosi into the receive register LSB and increment the bit counter.
REQ-020 In SHIFT, on each sclk falling edge, SHALL shift the next transmit bit onto miso.
REQ-021 When the counter reaches WIDTH on a rising edge, SHALL enter DONE, load rx_data, and pulse rx_valid on the following clk cycle, giving a latency of at most SYNC_STAGES+2 clk cycles from the last sclk rising edge at the pins.
REQ-022 In DONE, SHALL ignore further sclk edges and return to IDLE on cs rising; a new cs falling edge in DONE without an intervening rise SHALL NOT occur (it is a protocol violation).
REQ-023 A cs rising edge in SHIFT with counter < WIDTH SHALL pulse frame_err, leave rx_data unchanged, produce no rx_valid, and return to IDLE; the aborted reply SHALL NOT be restored.
REQ-024 A tx_load in the same cycle as the REQ-018 capture SHALL be written to the pending register after the capture and leave tx_pending=1, so it is used for the next frame.
REQ-025 A tx_load while tx_pending=1 SHALL overwrite the pending word (last write wins).
REQ-026 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within a frame.
REQ-027 miso SHALL be 0 when miso_oe=0.

Reset
REQ-028 reset=0 SHALL force, asynchronously: state=IDLE, miso=0, miso_oe=0, tx_pending=0, rx_data=0, rx_valid=0, frame_err=0, counter=0, synchronizers to the idle level (cs=1, sclk=0).
REQ-029 Reset asserted mid-frame SHALL discard the frame with no rx_valid or frame_err; after release, SHALL wait for a fresh cs falling edge.

Structure
REQ-030 spi_pkg SHALL hold the state enum type spi_state_t and the constant SPI_WIDTH=8.
REQ-031 Synchronization SHALL be a sub-module spi_sync (parameterized depth and reset value), instantiated once per input.

Verification
REQ-032 Load tx_data=0x05, master sends 0xA3 at 12.5 MHz -> master reads 0x05; rx_data=0xA3 with one rx_valid pulse; tx_pending falls at cs low.
REQ-033 No tx_load, master sends 0x01 -> master reads 0x00; rx_data=0x01.
REQ-034 cs rises after 5 bits -> frame_err pulse, no rx_valid, rx_data holds its previous value; next full frame of 0x02 received correctly.
REQ-035 tx_load of 0x07 in the exact cycle of the synchronized cs fall with pending 0x03 -> this frame returns 0x03, next frame returns 0x07.
REQ-036 reset=0 asserted after 4 bits -> all outputs are 0 immediately without waiting for clk; after release, frame 0x09 is received correctly.
REQ-037 Two tx_loads (0x04 then 0x08) before the frame -> master reads 0x08; back-to-back frames with 4 clk of cs high both complete.
